// File: rtl/hazard_req_gen_if.sv
// hazard_req_gen_if: pipeline hazard inputs and stall-request outputs of hazard_req_gen
interface hazard_req_gen_if;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic        d_use_rs1;
    logic        d_use_rs2;
    logic [4:0]  x_rd;
    logic        x_reg_write;
    logic        x_mem_read;
    logic        x_muldiv_start;
    logic        x_muldiv_is_div;
    logic        m_mem_req;
    logic        m_mem_ready;
    logic        stat_clr;
    logic [4:0]  F_D_X_M_W_clt;
    logic        md_busy;
    logic        md_done;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    modport master (
        output d_rs1, d_rs2, d_use_rs1, d_use_rs2, x_rd, x_reg_write, x_mem_read,
               x_muldiv_start, x_muldiv_is_div, m_mem_req, m_mem_ready, stat_clr,
        input  F_D_X_M_W_clt, md_busy, md_done, mem_timeout, stall_cycles
    );
    modport slave (
        input  d_rs1, d_rs2, d_use_rs1, d_use_rs2, x_rd, x_reg_write, x_mem_read,
               x_muldiv_start, x_muldiv_is_div, m_mem_req, m_mem_ready, stat_clr,
        output F_D_X_M_W_clt, md_busy, md_done, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_req_gen.sv
// hazard_req_gen: load-use, mul/div and memory-wait stall request generator with stall statistics
module hazard_req_gen #(
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 33,
    parameter int MEM_TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    hazard_req_gen_if.slave bus
);
    localparam int CW = $clog2((DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES) + 1);
    typedef enum logic {IDLE, MD_BUSY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] md_cnt, cnt_nxt;
    logic [7:0] mem_wait_cnt, wait_inc;
    logic [15:0] stall_cycles;
    logic [4:0] clt;
    logic lu, mem_wait, md_req, busy_c, done_c, mem_timeout;
    assign lu = bus.x_mem_read & bus.x_reg_write & (bus.x_rd != 5'd0) &
                ((bus.d_use_rs1 & (bus.d_rs1 == bus.x_rd)) | (bus.d_use_rs2 & (bus.d_rs2 == bus.x_rd)));
    assign mem_wait = bus.m_mem_req & ~bus.m_mem_ready;
    assign wait_inc = (mem_wait_cnt == 8'hFF) ? 8'hFF : mem_wait_cnt + 8'd1;
    // reset masks the sequenced mul/div terms so only the combinational hazards show through
    assign clt = (lu ? 5'b00011 : 5'b00000) | ((md_req & ~rst) ? 5'b00111 : 5'b00000) |
                 (mem_wait ? 5'b01111 : 5'b00000);
    always_comb begin
        state_nxt = state;
        cnt_nxt = md_cnt;
        md_req = 1'b0;
        busy_c = 1'b0;
        done_c = 1'b0;
        if (state == IDLE) begin
            md_req = bus.x_muldiv_start;
            cnt_nxt = bus.x_muldiv_start ? (bus.x_muldiv_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1)) : md_cnt;
            state_nxt = bus.x_muldiv_start ? MD_BUSY : IDLE;
        end else if (md_cnt != '0) begin
            md_req = 1'b1;
            busy_c = 1'b1;
            cnt_nxt = md_cnt - CW'(1);
        end else begin
            done_c = 1'b1;
            state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            md_cnt <= '0;
            mem_wait_cnt <= 8'd0;
            mem_timeout <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state <= state_nxt;
            md_cnt <= cnt_nxt;
            mem_wait_cnt <= mem_wait ? wait_inc : 8'd0;
            mem_timeout <= mem_timeout | (mem_wait & (wait_inc == 8'(MEM_TIMEOUT)));
            stall_cycles <= bus.stat_clr ? 16'd0 :
                            ((clt != 5'd0) && (stall_cycles != 16'hFFFF)) ? stall_cycles + 16'd1 : stall_cycles;
        end
    end
    assign bus.F_D_X_M_W_clt = clt;
    assign bus.md_busy = busy_c & ~rst;
    assign bus.md_done = done_c & ~rst;
    assign bus.mem_timeout = mem_timeout;
    assign bus.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_req_gen.sv
// tb_hazard_req_gen: table vectors plus hand-written mul/div, timeout, reset and saturation sequences
module tb_hazard_req_gen;
    logic clk;
    logic rst;
    int tests;
    int fails;
    int exp_stall;
    hazard_req_gen_if bus();
    hazard_req_gen dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, xrd;
        logic       u1, u2, xw, xr, mreq, mrdy;
        logic [4:0] exp;
    } vec_t;
    typedef struct {
        string      name;
        logic [4:0] exp;
    } sb_t;
    vec_t tbl[10];
    sb_t sb[$];
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic idle_in();
        bus.d_rs1 = 5'd0; bus.d_rs2 = 5'd0; bus.d_use_rs1 = 1'b0; bus.d_use_rs2 = 1'b0;
        bus.x_rd = 5'd0; bus.x_reg_write = 1'b0; bus.x_mem_read = 1'b0;
        bus.x_muldiv_start = 1'b0; bus.x_muldiv_is_div = 1'b0;
        bus.m_mem_req = 1'b0; bus.m_mem_ready = 1'b0; bus.stat_clr = 1'b0;
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    // expected clt is queued with the stimulus and retired at the sampling edge
    task automatic cyc(input string nm, input logic [4:0] exp);
        sb_t e;
        sb.push_back('{nm, exp});
        @(negedge clk);
        e = sb.pop_front();
        chk(e.name, 32'(bus.F_D_X_M_W_clt), 32'(e.exp));
    endtask
    initial begin
        tbl[0] = '{"lu_rs2",       5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00011};
        tbl[1] = '{"lu_x0",        5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tbl[2] = '{"lu_rs1",       5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00011};
        tbl[3] = '{"lu_rs1_unused",5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tbl[4] = '{"lu_not_load",  5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[5] = '{"lu_no_write",  5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000};
        tbl[6] = '{"mem_wait",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01111};
        tbl[7] = '{"mem_ready",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000};
        tbl[8] = '{"lu_and_wait",  5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b01111};
        tbl[9] = '{"lu_no_match",  5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tests = 0; fails = 0; exp_stall = 0;
        clk = 1'b0; rst = 1'b1;
        idle_in();
        #1;
        bus.x_mem_read = 1'b1; bus.x_reg_write = 1'b1; bus.x_rd = 5'd7;
        bus.d_use_rs1 = 1'b1; bus.d_rs1 = 5'd7; bus.x_muldiv_start = 1'b1;
        cyc("rst_lu_only", 5'b00011);
        next();
        idle_in();
        cyc("rst_hold", 5'b00000);
        chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
        chk("rst_md_done", 32'(bus.md_done), 32'd0);
        chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
        chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
        next();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.d_rs1 = tbl[i].rs1; bus.d_rs2 = tbl[i].rs2; bus.x_rd = tbl[i].xrd;
            bus.d_use_rs1 = tbl[i].u1; bus.d_use_rs2 = tbl[i].u2;
            bus.x_reg_write = tbl[i].xw; bus.x_mem_read = tbl[i].xr;
            bus.m_mem_req = tbl[i].mreq; bus.m_mem_ready = tbl[i].mrdy;
            cyc(tbl[i].name, tbl[i].exp);
            next();
            if (tbl[i].exp != 5'd0) exp_stall++;
        end
        idle_in();
        cyc("tbl_idle", 5'b00000);
        chk("tbl_stall", 32'(bus.stall_cycles), 32'(exp_stall));
        next();
        bus.stat_clr = 1'b1;
        cyc("clr_cycle", 5'b00000);
        next();
        bus.stat_clr = 1'b0;
        bus.x_muldiv_start = 1'b1; bus.x_muldiv_is_div = 1'b0;
        cyc("mul_t0", 5'b00111);
        chk("mul_stall_cleared", 32'(bus.stall_cycles), 32'd0);
        for (int k = 1; k < 4; k++) begin
            next();
            bus.x_muldiv_is_div = 1'b1;
            cyc("mul_busy", 5'b00111);
            chk("mul_md_busy", 32'(bus.md_busy), 32'd1);
            chk("mul_no_done", 32'(bus.md_done), 32'd0);
        end
        next();
        bus.x_muldiv_start = 1'b0;
        cyc("mul_release", 5'b00000);
        chk("mul_md_done", 32'(bus.md_done), 32'd1);
        chk("mul_md_busy_off", 32'(bus.md_busy), 32'd0);
        next();
        bus.x_muldiv_start = 1'b1; bus.x_muldiv_is_div = 1'b0;
        cyc("mul_restart", 5'b00111);
        chk("mul_stall_4", 32'(bus.stall_cycles), 32'd4);
        chk("mul_done_pulse", 32'(bus.md_done), 32'd0);
        for (int k = 1; k < 4; k++) begin
            next();
            bus.x_muldiv_start = 1'b0;
            cyc("mul2_busy", 5'b00111);
        end
        next();
        cyc("mul2_release", 5'b00000);
        chk("mul2_md_done", 32'(bus.md_done), 32'd1);
        next();
        cyc("mul2_idle", 5'b00000);
        chk("mul2_stall_8", 32'(bus.stall_cycles), 32'd8);
        for (int k = 0; k <= 33; k++) begin
            next();
            bus.x_muldiv_start = (k == 0);
            bus.x_muldiv_is_div = 1'b1;
            bus.m_mem_req = (k >= 2 && k <= 4);
            cyc("div_mem", (k == 33) ? 5'b00000 : (k >= 2 && k <= 4) ? 5'b01111 : 5'b00111);
            chk("div_done", 32'(bus.md_done), 32'(k == 33));
        end
        next();
        idle_in();
        for (int k = 0; k < 255; k++) begin
            bus.m_mem_req = 1'b1; bus.m_mem_ready = 1'b0;
            cyc("to_wait", 5'b01111);
            if (k == 254) chk("to_not_yet", 32'(bus.mem_timeout), 32'd0);
            next();
        end
        bus.m_mem_ready = 1'b1;
        cyc("to_ready", 5'b00000);
        chk("to_set", 32'(bus.mem_timeout), 32'd1);
        next();
        idle_in();
        repeat (3) next();
        @(negedge clk);
        chk("to_sticky", 32'(bus.mem_timeout), 32'd1);
        next();
        for (int k = 0; k < 40; k++) begin
            bus.x_muldiv_start = (k == 0);
            bus.x_muldiv_is_div = 1'b1;
            rst = (k == 2);
            cyc("rstdiv_clt", (k < 2) ? 5'b00111 : 5'b00000);
            chk("rstdiv_no_done", 32'(bus.md_done), 32'd0);
            if (k == 3) begin
                chk("rstdiv_busy", 32'(bus.md_busy), 32'd0);
                chk("rstdiv_timeout", 32'(bus.mem_timeout), 32'd0);
            end
            next();
        end
        bus.x_muldiv_start = 1'b0;
        bus.m_mem_req = 1'b1; bus.m_mem_ready = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_sat", 32'(bus.stall_cycles), 32'hFFFF);
        next();
        bus.stat_clr = 1'b1;
        cyc("clr_with_stall", 5'b01111);
        next();
        bus.stat_clr = 1'b0;
        @(negedge clk);
        chk("clr_priority", 32'(bus.stall_cycles), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_req_gen.md
HAZARD_REQ_GEN -- requirements
Module: hazard_req_gen

Interface
REQ-001 Parameters (one per line: name, default, meaning):
  MUL_CYCLES, 4, total stall cycles for a multiply (legal range >=2).
  DIV_CYCLES, 33, total stall cycles for a divide (legal range >=2).
  MEM_TIMEOUT, 255, consecutive memory-wait cycles that set the timeout flag.
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  d_rs1  in  5  D-stage source register 1.
  d_rs2  in  5  D-stage source register 2.
  d_use_rs1  in  1  D-stage instruction reads rs1.
  d_use_rs2  in  1  D-stage instruction reads rs2.
  x_rd  in  5  X-stage destination register.
  x_reg_write  in  1  X-stage instruction writes x_rd.
  x_mem_read  in  1  X-stage instruction is a load.
  x_muldiv_start  in  1  X-stage issues a mul/div this cycle.
  x_muldiv_is_div  in  1  1 = divide, 0 = multiply; valid with start.
  m_mem_req  in  1  M-stage memory access pending.
  m_mem_ready  in  1  memory completes the access this cycle.
  stat_clr  in  1  clears the stall statistics counter.
  F_D_X_M_W_clt  out  5  per-stage hold request, bit0=F ... bit4=W; feeds the pipeline stall controller.
  md_busy  out  1  mul/div sequence in progress.
  md_done  out  1  one-cycle pulse when the mul/div stall is released.
  mem_timeout  out  1  sticky memory-timeout error flag.
  stall_cycles  out  16  saturating count of stalled cycles.

Function
REQ-003 F_D_X_M_W_clt SHALL be the bitwise OR of the load-use, mul/div and memory-wait request vectors defined below, all evaluated in the same cycle.
REQ-004 Load-use (combinational): when x_mem_read & x_reg_write & x_rd!=0 & ((d_use_rs1 & d_rs1==x_rd) | (d_use_rs2 & d_rs2==x_rd)), the block SHALL contribute 5'b00011.
REQ-005 A hazard on register x0 SHALL never raise a load-use request.
REQ-006 The FSM SHALL have two states, IDLE and MD_BUSY.
REQ-007 In IDLE with x_muldiv_start=1, the block SHALL:
  contribute 5'b00111 in that same cycle;
  load md_cnt with (x_muldiv_is_div ? DIV_CYCLES : MUL_CYCLES) - 1;
  enter MD_BUSY.
REQ-008 In MD_BUSY with md_cnt!=0, the block SHALL contribute 5'b00111, decrement md_cnt and assert md_busy.
REQ-009 In MD_BUSY with md_cnt==0, the block SHALL:
  contribute no mul/div request;
  pulse md_done=1 for that cycle;
  return to IDLE.
  Total mul/div stall is exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-010 x_muldiv_start SHALL be ignored while in MD_BUSY.
REQ-011 A new start in the IDLE cycle immediately after md_done SHALL be accepted.
REQ-012 The mul/div counter SHALL keep decrementing while a memory-wait stall is also active.
REQ-013 Memory wait (combinational): when m_mem_req & ~m_mem_ready, the block SHALL contribute 5'b01111. Bit 4 (W) is never requested by this block.
REQ-014 mem_wait_cnt (8-bit):
  increments each memory-wait cycle, saturating at 255;
  clears on any cycle without memory wait.
REQ-015 When mem_wait_cnt reaches MEM_TIMEOUT during a wait, mem_timeout SHALL set and stay set until rst.
REQ-016 stall_cycles SHALL increment on every cycle with F_D_X_M_W_clt!=0 and saturate at 16'hFFFF.
REQ-017 stat_clr SHALL zero stall_cycles; it has priority over a same-cycle increment.

Reset
REQ-018 With rst=1 at a clock edge, the block SHALL set:
  state=IDLE, md_cnt=0, mem_wait_cnt=0;
  md_busy=0, md_done=0, mem_timeout=0, stall_cycles=0.
REQ-019 Reset during MD_BUSY SHALL abort the sequence: no md_done pulse, and no mul/div request from the cycle after reset.
REQ-020 While rst=1, F_D_X_M_W_clt SHALL reflect only the combinational load-use and memory-wait terms.

Verification
REQ-021 Load-use: x_mem_read=1, x_reg_write=1, x_rd=5, d_use_rs2=1, d_rs2=5 -> clt=5'b00011 for one cycle. Same with x_rd=0 -> clt=5'b00000.
REQ-022 Multiply: start at cycle T with is_div=0 -> clt=5'b00111 on T..T+3, clt=0 and md_done=1 on T+4, stall_cycles=4.
REQ-023 Divide overlapping a memory wait: start at T, memory wait on T+2..T+4 -> clt=5'b01111 on T+2..T+4, 5'b00111 otherwise through T+32, md_done on T+33.
REQ-024 Timeout: m_mem_req=1, m_mem_ready=0 held 255 cycles -> mem_timeout=1 and stays 1 after the ready arrives.
REQ-025 rst asserted at T+2 of a divide -> clt=0 from T+3, md_busy=0, no md_done. Separately, stall_cycles preset near 16'hFFFF saturates, and stat_clr with a concurrent stall -> stall_cycles=0.
